// File: rtl/cart_pkg.sv
// rtl/cart_pkg.sv - shared types and helpers for the cartridge loader
// Contents:
//   cart_state_t  loader FSM states (IDLE, LOAD, HOLD, RUN)
//   hold_cnt_w()  bit width needed to hold a post-load reset count
package cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } cart_state_t;

  // Smallest width w with 2**w > cycles, so the counter can hold the value itself.
  function automatic int hold_cnt_w(input int cycles);
    int w;
    w = 1;
    while (w < 31 && (1 << w) <= cycles) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/pow2_mask.sv
// rtl/pow2_mask.sv - combinational next-power-of-two mask of a byte count
// Ports:
//   size  in  W+1  byte count, 0 .. 2**W
//   mask  out W    (next power of two >= size) - 1, or 0 when size is 0
module pow2_mask
  import cart_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W:0]   size,
  output logic [W-1:0] mask
);

  logic [W-1:0] smear;

  always_comb begin
    // size-1 fits in W bits for every legal size; 2**W wraps to all ones.
    smear = size[W-1:0] - {{(W-1){1'b0}}, 1'b1};
    for (int s = 1; s < W; s = s * 2) begin
      smear = smear | (smear >> s);
    end
    mask = (size == '0) ? '0 : smear;
  end

endmodule

// File: rtl/cart_loader.sv
// rtl/cart_loader.sv - cartridge download to memory with console reset sequencing
// Ports:
//   clk_sys         in   sole clock
//   reset           in   asynchronous active-high reset
//   rst_req         in   level reset request from OSD/button
//   ioctl_download  in   download active
//   ioctl_index     in   download slot, [5:0] compared with CART_INDEX
//   ioctl_wr        in   byte strobe
//   ioctl_addr      in   byte address
//   ioctl_dout      in   byte data
//   mem_a/mem_d/mem_we out  registered memory write port (1 cycle after strobe)
//   core_reset      out  reset to the console core
//   loaded          out  a non-empty cartridge is present
//   overflow        out  sticky: a byte beyond 2**ADDR_W was dropped
//   cart_size       out  highest accepted address + 1
//   cart_mask       out  next power of two >= cart_size, minus 1
module cart_loader
  import cart_pkg::*;
#(
  parameter int              ADDR_W      = 16,
  parameter int              HOLD_CYCLES = 255,
  parameter logic [5:0]      CART_INDEX  = 6'd1,
  parameter logic [ADDR_W-1:0] BASE      = '0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              rst_req,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_d,
  output logic              mem_we,
  output logic              core_reset,
  output logic              loaded,
  output logic              overflow,
  output logic [ADDR_W:0]   cart_size,
  output logic [ADDR_W-1:0] cart_mask
);

  localparam int               CNT_W     = hold_cnt_w(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  cart_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_d_q, mem_d_d;
  logic              loaded_q, loaded_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W:0]   cart_size_q, cart_size_d;
  logic [ADDR_W-1:0] cart_mask_q, cart_mask_d;

  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W:0]   byte_end;
  logic              in_range;
  logic              index_hit;
  logic              disturb;
  logic              unused_index;

  assign addr_lo      = ioctl_addr[ADDR_W-1:0];
  assign byte_end     = {1'b0, addr_lo} + {{ADDR_W{1'b0}}, 1'b1};
  assign in_range     = (ioctl_addr >> ADDR_W) == 25'd0;
  assign index_hit    = ioctl_download && (ioctl_index[5:0] == CART_INDEX);
  // Any download (ours or a foreign slot) or a user request keeps the core quiet.
  assign disturb      = rst_req || ioctl_download;
  assign unused_index = ^ioctl_index[7:6];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_a_d     = mem_a_q;
    mem_d_d     = mem_d_q;
    loaded_d    = loaded_q;
    overflow_d  = overflow_q;
    cart_size_d = cart_size_q;

    if (state_q != ST_LOAD && index_hit) begin
      // A matching download pre-empts everything, including rst_req.
      state_d     = ST_LOAD;
      loaded_d    = 1'b0;
      overflow_d  = 1'b0;
      cart_size_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Nothing to wait for after reset: let a previously stored image boot.
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
        ST_LOAD: begin
          if (!ioctl_download) begin
            state_d  = ST_HOLD;
            cnt_d    = HOLD_INIT;
            loaded_d = (cart_size_q != '0);
          end else if (ioctl_wr) begin
            if (in_range) begin
              mem_we_d = 1'b1;
              mem_a_d  = addr_lo + BASE;
              mem_d_d  = ioctl_dout;
              if (byte_end > cart_size_q) cart_size_d = byte_end;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (disturb) begin
            cnt_d = HOLD_INIT;
          end else if (cnt_q == CNT_ONE) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_RUN: begin
          if (disturb) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_INIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Mask tracks the next-cycle size so it is valid the same cycle cart_size is.
  pow2_mask #(.W(ADDR_W)) u_pow2_mask (
    .size (cart_size_d),
    .mask (cart_mask_d)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= HOLD_INIT;
      mem_we_q    <= 1'b0;
      mem_a_q     <= '0;
      mem_d_q     <= '0;
      loaded_q    <= 1'b0;
      overflow_q  <= 1'b0;
      cart_size_q <= '0;
      cart_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_a_q     <= mem_a_d;
      mem_d_q     <= mem_d_d;
      loaded_q    <= loaded_d;
      overflow_q  <= overflow_d;
      cart_size_q <= cart_size_d;
      cart_mask_q <= cart_mask_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_a      = mem_a_q;
  assign mem_d      = mem_d_q;
  assign loaded     = loaded_q;
  assign overflow   = overflow_q;
  assign cart_size  = cart_size_q;
  assign cart_mask  = cart_mask_q;
  assign core_reset = (state_q != ST_RUN) || disturb;

endmodule
